// File: rtl/uart_transmitter_if.sv
// Byte handshake between the UART address decoder (producer) and the transmitter.
// The producer drives DataIn/DataInValid; the transmitter answers with DataInReady.
interface uart_transmitter_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (
        output DataIn,
        output DataInValid,
        input  DataInReady
    );

    modport slave (
        input  DataIn,
        input  DataInValid,
        output DataInReady
    );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 serial transmit engine: takes one byte per ready/valid handshake and
// shifts it out LSB first on SOut, framed by a start bit and a stop bit.
module uart_transmitter #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic                Clock,
    input  logic                Reset,
    uart_transmitter_if.slave   bus,
    output logic                SOut
);
    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int SymCntWidth    = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam logic [SymCntWidth-1:0] SymLast = SymCntWidth'(SymbolEdgeTime - 1);

    generate
        if (SymbolEdgeTime < 2) begin : g_bad_baud
            $error("uart_transmitter: ClockFreq/BaudRate must be at least 2");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_reg,   state_next;
    logic [9:0]             shift_reg,   shift_next;
    logic [SymCntWidth-1:0] sym_cnt_reg, sym_cnt_next;
    logic [3:0]             bit_cnt_reg, bit_cnt_next;
    logic                   sym_done;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '1;
            sym_cnt_reg <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            sym_cnt_reg <= sym_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        sym_cnt_next    = sym_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        bus.DataInReady = 1'b0;
        SOut            = 1'b1;
        sym_done        = (sym_cnt_reg == SymLast);

        case (state_reg)
            IDLE: begin
                bus.DataInReady = 1'b1;
                if (bus.DataInValid) begin
                    // Frame is {stop, data, start}; bit 0 goes on the line first.
                    shift_next   = {1'b1, bus.DataIn, 1'b0};
                    sym_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                SOut = shift_reg[0];
                if (sym_done) begin
                    sym_cnt_next = '0;
                    shift_next   = {1'b1, shift_reg[9:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd9) begin
                        state_next = IDLE;
                    end
                end else begin
                    sym_cnt_next = sym_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: one instance at default rates, one at T=8 for
// the timing-heavy scenarios. Expected line bits are queued when a byte is sent.
module tb_uart_transmitter;
    localparam int TD = 50_000_000 / 115_200;
    localparam int TS = 8;

    logic clk;
    logic rst_d;
    logic rst_s;
    logic sout_d;
    logic sout_s;
    int   cyc;
    int   passed;
    int   total;
    bit   exp_q[$];

    uart_transmitter_if bus_d ();
    uart_transmitter_if bus_s ();

    uart_transmitter dut_d (
        .Clock (clk),
        .Reset (rst_d),
        .bus   (bus_d.slave),
        .SOut  (sout_d)
    );

    uart_transmitter #(
        .ClockFreq (8),
        .BaudRate  (1)
    ) dut_s (
        .Clock (clk),
        .Reset (rst_s),
        .bus   (bus_s.slave),
        .SOut  (sout_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Returns at the falling edge inside cycle c (the cycle that follows edge c-1).
    task automatic goto_cyc(input int c);
        @(negedge clk);
        while (cyc < c - 1) @(negedge clk);
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
    endtask

    task automatic send_s(input logic [7:0] d, input bit hold, output int a);
        int n;
        @(negedge clk);
        bus_s.DataIn      = d;
        bus_s.DataInValid = 1'b1;
        n = 0;
        while (!bus_s.DataInReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus_s.DataInReady !== 1'b1)
            $display("FAIL send_accept: DataInReady=%b required 1 (byte %h)", bus_s.DataInReady, d);
        else
            passed++;
        a = cyc + 1;
        push_frame(d);
        @(posedge clk);
        #1;
        if (!hold) bus_s.DataInValid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_d             = 1'b1;
        bus_d.DataInValid = 1'b1;
        bus_d.DataIn      = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (sout_d !== 1'b1) $display("FAIL reset_sout: SOut=%b required 1 (cycle %0d)", sout_d, i);
            else passed++;
            total++;
            if (bus_d.DataInReady !== 1'b1) $display("FAIL reset_ready: DataInReady=%b required 1 (cycle %0d)", bus_d.DataInReady, i);
            else passed++;
        end
        rst_d             = 1'b0;
        bus_d.DataInValid = 1'b0;
        @(negedge clk);
        total++;
        if (sout_d !== 1'b1 || bus_d.DataInReady !== 1'b1)
            $display("FAIL reset_no_frame: SOut=%b DataInReady=%b required 1/1", sout_d, bus_d.DataInReady);
        else passed++;
        $display("reset: done");
    endtask

    task automatic test_single_byte();
        int a;
        int n;
        bit e;
        @(negedge clk);
        bus_d.DataIn      = 8'hA5;
        bus_d.DataInValid = 1'b1;
        n = 0;
        while (!bus_d.DataInReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus_d.DataInReady !== 1'b1) $display("FAIL single_accept: DataInReady=%b required 1", bus_d.DataInReady);
        else passed++;
        a = cyc + 1;
        push_frame(8'hA5);
        @(posedge clk);
        #1;
        bus_d.DataInValid = 1'b0;
        goto_cyc(a + 1);
        total++;
        if (sout_d !== 1'b0) $display("FAIL single_latency: SOut=%b required 0 at A+1", sout_d);
        else passed++;
        for (int k = 0; k < 10; k++) begin
            goto_cyc(a + 1 + k * TD + TD / 2);
            e = exp_q.pop_front();
            total++;
            if (sout_d !== e) $display("FAIL single_bit%0d: SOut=%b required %b", k, sout_d, e);
            else passed++;
        end
        goto_cyc(a + 10 * TD);
        total++;
        if (bus_d.DataInReady !== 1'b0) $display("FAIL single_busy_end: DataInReady=%b required 0 at A+10T", bus_d.DataInReady);
        else passed++;
        goto_cyc(a + 10 * TD + 1);
        total++;
        if (bus_d.DataInReady !== 1'b1) $display("FAIL single_ready_back: DataInReady=%b required 1 at A+10T+1", bus_d.DataInReady);
        else passed++;
        $display("single_byte: A5 frame sampled, accept edge %0d", a);
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        bit e;
        send_s(8'h00, 1'b1, a1);
        bus_s.DataIn = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            goto_cyc(a1 + 1 + k * TS + TS / 2);
            e = exp_q.pop_front();
            total++;
            if (sout_s !== e) $display("FAIL b2b_f1_bit%0d: SOut=%b required %b", k, sout_s, e);
            else passed++;
        end
        goto_cyc(a1 + 10 * TS);
        total++;
        if (bus_s.DataInReady !== 1'b0) $display("FAIL b2b_busy_end: DataInReady=%b required 0", bus_s.DataInReady);
        else passed++;
        goto_cyc(a1 + 10 * TS + 1);
        total++;
        if (bus_s.DataInReady !== 1'b1 || sout_s !== 1'b1)
            $display("FAIL b2b_gap: DataInReady=%b SOut=%b required 1/1", bus_s.DataInReady, sout_s);
        else passed++;
        a2 = a1 + 10 * TS + 1;
        push_frame(8'hFF);
        goto_cyc(a2 + 1);
        total++;
        if (sout_s !== 1'b0) $display("FAIL b2b_f2_start: SOut=%b required 0 at A+82", sout_s);
        else passed++;
        for (int k = 0; k < 10; k++) begin
            goto_cyc(a2 + 1 + k * TS + TS / 2);
            e = exp_q.pop_front();
            total++;
            if (sout_s !== e) $display("FAIL b2b_f2_bit%0d: SOut=%b required %b", k, sout_s, e);
            else passed++;
        end
        bus_s.DataInValid = 1'b0;
        goto_cyc(a2 + 10 * TS + 1);
        total++;
        if (bus_s.DataInReady !== 1'b1) $display("FAIL b2b_ready_back: DataInReady=%b required 1", bus_s.DataInReady);
        else passed++;
        $display("back_to_back: 00 then FF, accepts at %0d and %0d", a1, a2);
    endtask

    task automatic test_busy_drop();
        int a;
        int bad;
        bit e;
        send_s(8'h3C, 1'b0, a);
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                goto_cyc(a + 20);
                bus_s.DataIn      = 8'hC3;
                bus_s.DataInValid = 1'b1;
            end
            goto_cyc(a + 1 + k * TS + TS / 2);
            if (k == 2) bus_s.DataInValid = 1'b0;
            e = exp_q.pop_front();
            total++;
            if (sout_s !== e) $display("FAIL busy_drop_bit%0d: SOut=%b required %b", k, sout_s, e);
            else passed++;
        end
        goto_cyc(a + 10 * TS + 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (sout_s !== 1'b1 || bus_s.DataInReady !== 1'b1) bad++;
            @(negedge clk);
        end
        total++;
        if (bad != 0) $display("FAIL busy_drop_idle: %0d non-idle cycles after stop bit, required 0", bad);
        else passed++;
        total++;
        if (exp_q.size() != 0) $display("FAIL busy_drop_queue: %0d expected bits left, required 0", exp_q.size());
        else passed++;
        $display("busy_drop: 3C sent, C3 pulse during SEND ignored");
    endtask

    task automatic test_reset_mid_frame();
        int a;
        int a2;
        bit e;
        send_s(8'h0F, 1'b0, a);
        for (int k = 0; k < 3; k++) begin
            goto_cyc(a + 1 + k * TS + TS / 2);
            e = exp_q.pop_front();
            total++;
            if (sout_s !== e) $display("FAIL rst_mid_bit%0d: SOut=%b required %b", k, sout_s, e);
            else passed++;
        end
        goto_cyc(a + 3 * TS + 2);
        rst_s = 1'b1;
        goto_cyc(a + 3 * TS + 3);
        exp_q.delete();
        total++;
        if (sout_s !== 1'b1 || bus_s.DataInReady !== 1'b1)
            $display("FAIL rst_mid_after: SOut=%b DataInReady=%b required 1/1", sout_s, bus_s.DataInReady);
        else passed++;
        rst_s = 1'b0;
        goto_cyc(a + 3 * TS + 12);
        total++;
        if (sout_s !== 1'b1) $display("FAIL rst_mid_abandon: SOut=%b required 1", sout_s);
        else passed++;
        send_s(8'hF0, 1'b0, a2);
        for (int k = 0; k < 10; k++) begin
            goto_cyc(a2 + 1 + k * TS + TS / 2);
            e = exp_q.pop_front();
            total++;
            if (sout_s !== e) $display("FAIL rst_mid_f2_bit%0d: SOut=%b required %b", k, sout_s, e);
            else passed++;
        end
        goto_cyc(a2 + 10 * TS);
        total++;
        if (bus_s.DataInReady !== 1'b0) $display("FAIL rst_mid_f2_busy: DataInReady=%b required 0", bus_s.DataInReady);
        else passed++;
        goto_cyc(a2 + 10 * TS + 1);
        total++;
        if (bus_s.DataInReady !== 1'b1) $display("FAIL rst_mid_f2_ready: DataInReady=%b required 1", bus_s.DataInReady);
        else passed++;
        $display("reset_mid_frame: 0F abandoned, F0 resent at %0d", a2);
    endtask

    task automatic test_input_stability();
        int a;
        int k;
        bit e;
        logic [7:0] rx;
        rx = 8'h00;
        send_s(8'h81, 1'b0, a);
        for (int c = a + 1; c <= a + 10 * TS; c++) begin
            goto_cyc(c);
            if ((c - a - 1) % TS == TS / 2) begin
                k = (c - a - 1) / TS;
                e = exp_q.pop_front();
                total++;
                if (sout_s !== e) $display("FAIL stable_bit%0d: SOut=%b required %b", k, sout_s, e);
                else passed++;
                if (k >= 1 && k <= 8) rx[k-1] = sout_s;
            end
            bus_s.DataIn = 8'($urandom);
        end
        total++;
        if (rx !== 8'h81) $display("FAIL stable_byte: decoded %h required 81", rx);
        else passed++;
        $display("input_stability: decoded %h", rx);
    endtask

    initial begin
        passed            = 0;
        total             = 0;
        rst_d             = 1'b1;
        rst_s             = 1'b1;
        bus_d.DataIn      = 8'h00;
        bus_d.DataInValid = 1'b0;
        bus_s.DataIn      = 8'h00;
        bus_s.DataInValid = 1'b0;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        rst_d = 1'b0;

        test_reset();
        test_single_byte();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid_frame();
        test_input_stability();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
